// File: rtl/sdram_arbiter_if.sv
// Client-side bus of the SDRAM arbiter: per-client request/done flags,
// packed command/address/bank/write-data slices and the one-hot grant.
interface sdram_arbiter_if #(
  parameter int NCH = 4,
  parameter int AW  = 12,
  parameter int BW  = 2,
  parameter int DW  = 16
);
  logic [NCH-1:0]    ch_ask;
  logic [NCH-1:0]    ch_end;
  logic [4*NCH-1:0]  ch_cmd;
  logic [AW*NCH-1:0] ch_addr;
  logic [BW*NCH-1:0] ch_bank;
  logic [DW*NCH-1:0] ch_wdata;
  logic [NCH-1:0]    ch_wr;
  logic [NCH-1:0]    ch_en;

  // Client side: raises requests and supplies command/data slices
  modport master (
    output ch_ask, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_wr,
    input  ch_en
  );

  // Arbiter side: consumes requests, returns the grant
  modport slave (
    input  ch_ask, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_wr,
    output ch_en
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: after initialisation, shares the SDRAM pins between
// the refresh engine (strict priority) and NCH round-robin access clients.
// The selected command/address/bank/data are registered onto the pins, and a
// watchdog forces release of any grant or refresh that overstays TIMEOUT.
module sdram_arbiter #(
  parameter int NCH     = 4,
  parameter int AW      = 12,
  parameter int BW      = 2,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          sclk,
  input  logic          srst,
  input  logic          init_end,
  input  logic [3:0]    init_cmd,
  input  logic [AW-1:0] init_addr,
  input  logic          aref_ask,
  input  logic          aref_end,
  input  logic [3:0]    aref_cmd,
  input  logic [AW-1:0] aref_addr,
  output logic          aref_en,
  sdram_arbiter_if.slave ch_if,
  output logic [3:0]    sdram_cmd,
  output logic [AW-1:0] sdram_addr,
  output logic [BW-1:0] sdram_bank,
  output logic [DW-1:0] dq_out,
  output logic          dq_oe,
  output logic [2:0]    gnt_id,
  output logic          busy,
  output logic          err_timeout
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARBIT,
    ST_AREF,
    ST_ACCESS
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      gnt_nxt;
  logic [2:0]      rr_id;
  logic            rr_hit;
  logic            wd_expire;
  logic            timeout_hit;
  logic [WDW-1:0]  wdog;
  int              sel_i;

  logic [3:0]      cmd_p0;
  logic [AW-1:0]   addr_p0;
  logic [BW-1:0]   bank_p0;
  logic [DW-1:0]   dq_p0;
  logic            oe_p0;

  // Slice index of the granted client; an out-of-range id falls back to 0
  always_comb begin
    sel_i = 0;
    if (int'(gnt_id) < NCH) sel_i = int'(gnt_id);
  end

  // Round-robin search: first requester upward from the client after the last grant
  always_comb begin : rr_search
    int idx;
    idx    = 0;
    rr_hit = 1'b0;
    rr_id  = 3'd0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (sel_i + k) % NCH;
      if (!rr_hit && ch_if.ch_ask[idx]) begin
        rr_hit = 1'b1;
        rr_id  = 3'(idx);
      end
    end
  end

  // The watchdog value counts completed cycles, so it equals TIMEOUT-1 on the
  // TIMEOUT-th cycle spent in AREF/ACCESS
  assign wd_expire = (wdog == WDW'(TIMEOUT - 1));

  // Next-state logic; an end flag always wins over the watchdog
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt_id;
    timeout_hit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (init_end) state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_ask) begin
          state_nxt = ST_AREF;
        end else if (rr_hit) begin
          state_nxt = ST_ACCESS;
          gnt_nxt   = rr_id;
        end
      end
      ST_AREF: begin
        if (aref_end) begin
          state_nxt = ST_ARBIT;
        end else if (wd_expire) begin
          state_nxt   = ST_ARBIT;
          timeout_hit = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (ch_if.ch_end[sel_i]) begin
          state_nxt = ST_ARBIT;
        end else if (wd_expire) begin
          state_nxt   = ST_ARBIT;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, grant pointer, watchdog and timeout pulse registers
  always_ff @(posedge sclk) begin
    if (srst) begin
      state       <= ST_IDLE;
      gnt_id      <= 3'(NCH - 1);
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt_id      <= gnt_nxt;
      err_timeout <= timeout_hit;
      if (state_nxt != state) begin
        wdog <= '0;
      end else if (state == ST_AREF || state == ST_ACCESS) begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  // Pin source selection by current state
  always_comb begin
    cmd_p0  = CMD_NOP;
    addr_p0 = '0;
    bank_p0 = '0;
    oe_p0   = 1'b0;
    dq_p0   = '0;
    unique case (state)
      ST_IDLE: begin
        cmd_p0  = init_cmd;
        addr_p0 = init_addr;
      end
      ST_AREF: begin
        cmd_p0  = aref_cmd;
        addr_p0 = aref_addr;
      end
      ST_ACCESS: begin
        cmd_p0  = ch_if.ch_cmd[sel_i*4 +: 4];
        addr_p0 = ch_if.ch_addr[sel_i*AW +: AW];
        bank_p0 = ch_if.ch_bank[sel_i*BW +: BW];
        oe_p0   = ch_if.ch_wr[sel_i];
        if (ch_if.ch_wr[sel_i]) dq_p0 = ch_if.ch_wdata[sel_i*DW +: DW];
      end
      default: ;
    endcase
  end

  // ---- stage p0 -> pins: registered SDRAM command/address/data ----
  always_ff @(posedge sclk) begin
    if (srst) begin
      sdram_cmd  <= CMD_NOP;
      sdram_addr <= '0;
      sdram_bank <= '0;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
    end else begin
      sdram_cmd  <= cmd_p0;
      sdram_addr <= addr_p0;
      sdram_bank <= bank_p0;
      dq_out     <= dq_p0;
      dq_oe      <= oe_p0;
    end
  end

  // Combinational grants; a pending refresh pauses the client without leaving ACCESS
  always_comb begin
    ch_if.ch_en = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_if.ch_en[i] = !srst && (state == ST_ACCESS) && (gnt_id == 3'(i)) && !aref_ask;
    end
  end

  assign aref_en = !srst && (state == ST_AREF);
  assign busy    = !srst && (state == ST_AREF || state == ST_ACCESS);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: scenario tasks with a round-robin reference
// model and randomized client data/request patterns.
module tb_sdram_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 12;
  localparam int BW  = 2;
  localparam int DW  = 16;
  localparam int TO  = 15;

  logic          sclk = 1'b0;
  logic          srst;
  logic          init_end;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic          aref_ask;
  logic          aref_end;
  logic [3:0]    aref_cmd;
  logic [AW-1:0] aref_addr;
  logic          aref_en;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [BW-1:0] sdram_bank;
  logic [DW-1:0] dq_out;
  logic          dq_oe;
  logic [2:0]    gnt_id;
  logic          busy;
  logic          err_timeout;

  sdram_arbiter_if #(.NCH(NCH), .AW(AW), .BW(BW), .DW(DW)) cif ();

  sdram_arbiter #(.NCH(NCH), .AW(AW), .BW(BW), .DW(DW), .TIMEOUT(TO)) dut (
    .sclk(sclk), .srst(srst), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_ask(aref_ask), .aref_end(aref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_en(aref_en),
    .ch_if(cif),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .dq_out(dq_out), .dq_oe(dq_oe), .gnt_id(gnt_id), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 sclk = ~sclk;

  int n_chk  = 0;
  int n_pass = 0;
  int last   = NCH - 1;

  logic [3:0]    cl_cmd  [NCH];
  logic [AW-1:0] cl_addr [NCH];
  logic [BW-1:0] cl_bank [NCH];
  logic [DW-1:0] cl_wdata[NCH];
  logic [NCH-1:0] cl_wr;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic pack_clients();
    for (int i = 0; i < NCH; i++) begin
      cif.ch_cmd[i*4 +: 4]     = cl_cmd[i];
      cif.ch_addr[i*AW +: AW]  = cl_addr[i];
      cif.ch_bank[i*BW +: BW]  = cl_bank[i];
      cif.ch_wdata[i*DW +: DW] = cl_wdata[i];
    end
    cif.ch_wr = cl_wr;
  endtask

  // Round-robin rule: first requester searching upward from last+1, wrapping
  function automatic int rr_pick(input int last_id, input logic [NCH-1:0] ask);
    for (int k = 1; k <= NCH; k++) begin
      if (ask[(last_id + k) % NCH]) return (last_id + k) % NCH;
    end
    return -1;
  endfunction

  // Bounded wait for a one-hot grant; returns the client index
  task automatic wait_grant(output int g, input int budget);
    g = -1;
    for (int c = 0; c < budget && g == -1; c++) begin
      if (cif.ch_en != '0) begin
        g = -2;
        for (int i = 0; i < NCH; i++) if (cif.ch_en == NCH'(1 << i)) g = i;
      end else begin
        step();
      end
    end
    n_chk++;
    if (g < 0) $display("FAIL grant_wait: ch_en=%b, want one-hot grant within %0d cycles", cif.ch_en, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    srst = 1'b1; init_end = 1'b0; aref_ask = 1'b0; aref_end = 1'b0;
    init_cmd = 4'b0010; init_addr = AW'($urandom);
    aref_cmd = 4'b0001; aref_addr = AW'($urandom);
    cif.ch_ask = '0; cif.ch_end = '0;
    for (int i = 0; i < NCH; i++) begin
      cl_cmd[i] = 4'($urandom); cl_addr[i] = AW'($urandom);
      cl_bank[i] = BW'($urandom); cl_wdata[i] = DW'($urandom);
    end
    cl_wr = NCH'($urandom);
    pack_clients();
    step(); step(); step();
    n_chk++; if (sdram_cmd !== 4'b0111) $display("FAIL rst_cmd: got %b want 0111", sdram_cmd); else n_pass++;
    n_chk++; if (sdram_addr !== '0 || sdram_bank !== '0) $display("FAIL rst_addr: got %h/%h want 0/0", sdram_addr, sdram_bank); else n_pass++;
    n_chk++; if (dq_oe !== 1'b0 || dq_out !== '0) $display("FAIL rst_dq: got oe=%b dq=%h want 0/0", dq_oe, dq_out); else n_pass++;
    n_chk++; if (gnt_id !== 3'd3) $display("FAIL rst_gnt: got %0d want 3", gnt_id); else n_pass++;
    n_chk++; if (err_timeout !== 1'b0) $display("FAIL rst_err: got %b want 0", err_timeout); else n_pass++;
    aref_ask = 1'b1; cif.ch_ask = '1;
    #1;
    n_chk++; if (aref_en !== 1'b0 || cif.ch_en !== '0 || busy !== 1'b0) $display("FAIL rst_hold: got aref_en=%b ch_en=%b busy=%b want 0", aref_en, cif.ch_en, busy); else n_pass++;
    // Release reset with requests present: IDLE must ignore them
    srst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_chk++; if (busy !== 1'b0 || cif.ch_en !== '0 || aref_en !== 1'b0) $display("FAIL idle_ignore: got busy=%b ch_en=%b aref_en=%b want 0", busy, cif.ch_en, aref_en); else n_pass++;
    end
    n_chk++; if (sdram_cmd !== init_cmd || sdram_addr !== init_addr || sdram_bank !== '0) $display("FAIL idle_mux: got %b/%h/%h want %b/%h/0", sdram_cmd, sdram_addr, sdram_bank, init_cmd, init_addr); else n_pass++;
    aref_ask = 1'b0; cif.ch_ask = '0;
  endtask

  task automatic test_init();
    for (int c = 0; c <= 7; c++) begin
      init_end = (c == 5);
      if (c == 6) begin
        n_chk++; if (sdram_cmd !== init_cmd) $display("FAIL init_c6: got %b want %b", sdram_cmd, init_cmd); else n_pass++;
      end
      if (c == 7) begin
        n_chk++; if (sdram_cmd !== 4'b0111 || sdram_addr !== '0) $display("FAIL init_c7: got %b/%h want 0111/0", sdram_cmd, sdram_addr); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL init_busy: got %b want 0", busy); else n_pass++;
      end
      step();
    end
    init_end = 1'b0;
  endtask

  // One access burst: ch_end three cycles after the grant appears
  task automatic serve(input int g, input logic [NCH-1:0] next_ask);
    n_chk++; if (gnt_id !== 3'(g) || busy !== 1'b1) $display("FAIL serve_gnt: got gnt=%0d busy=%b want %0d/1", gnt_id, busy, g); else n_pass++;
    step();
    n_chk++; if (sdram_cmd !== cl_cmd[g] || sdram_addr !== cl_addr[g] || sdram_bank !== cl_bank[g])
      $display("FAIL serve_mux: got %b/%h/%h want %b/%h/%h", sdram_cmd, sdram_addr, sdram_bank, cl_cmd[g], cl_addr[g], cl_bank[g]);
    else n_pass++;
    n_chk++; if (dq_oe !== cl_wr[g] || dq_out !== (cl_wr[g] ? cl_wdata[g] : DW'(0)))
      $display("FAIL serve_dq: got oe=%b dq=%h want oe=%b dq=%h", dq_oe, dq_out, cl_wr[g], cl_wr[g] ? cl_wdata[g] : DW'(0));
    else n_pass++;
    step(); step();
    cif.ch_end = NCH'(1 << g);
    cif.ch_ask = next_ask;
    step();
    cif.ch_end = '0;
    n_chk++; if (cif.ch_en !== '0) $display("FAIL serve_release: got ch_en=%b want 0", cif.ch_en); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order_fix[5] = '{0, 1, 2, 3, 0};
    int g;
    int exp_g;
    logic [NCH-1:0] ask;
    logic [NCH-1:0] nxt;
    ask = '1;
    cif.ch_ask = ask;
    for (int r = 0; r < 21; r++) begin
      exp_g = rr_pick(last, ask);
      wait_grant(g, 20);
      if (r < 5) begin
        n_chk++; if (g != order_fix[r]) $display("FAIL rr_order%0d: got %0d want %0d", r, g, order_fix[r]); else n_pass++;
      end
      n_chk++; if (g != exp_g) $display("FAIL rr_model%0d: got %0d want %0d (ask=%b)", r, g, exp_g, ask); else n_pass++;
      last = exp_g;
      if (r < 4) nxt = '1;
      else if (r == 20) nxt = '0;
      else nxt = NCH'($urandom_range(1, (1 << NCH) - 1));
      serve(exp_g, nxt);
      ask = nxt;
    end
  endtask

  task automatic test_aref_priority();
    int g;
    aref_ask = 1'b1; cif.ch_ask = 4'b0100;
    step();
    n_chk++; if (aref_en !== 1'b1 || cif.ch_en !== '0 || busy !== 1'b1) $display("FAIL pri_aref: got aref_en=%b ch_en=%b busy=%b want 1/0000/1", aref_en, cif.ch_en, busy); else n_pass++;
    aref_ask = 1'b0;
    step();
    n_chk++; if (sdram_cmd !== aref_cmd || sdram_addr !== aref_addr || sdram_bank !== '0) $display("FAIL pri_mux: got %b/%h/%h want %b/%h/0", sdram_cmd, sdram_addr, sdram_bank, aref_cmd, aref_addr); else n_pass++;
    aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    n_chk++; if (aref_en !== 1'b0) $display("FAIL pri_aref_end: got %b want 0", aref_en); else n_pass++;
    wait_grant(g, 4);
    n_chk++; if (g != 2 || gnt_id !== 3'd2) $display("FAIL pri_client: got %0d (gnt_id=%0d) want 2", g, gnt_id); else n_pass++;
    last = 2;
    cif.ch_end = 4'b0100; cif.ch_ask = '0;
    step();
    cif.ch_end = '0;
  endtask

  task automatic test_aref_pause();
    int g;
    cl_wr[1] = 1'b1;
    pack_clients();
    cif.ch_ask = 4'b0010;
    wait_grant(g, 5);
    n_chk++; if (g != rr_pick(last, 4'b0010)) $display("FAIL pause_grant: got %0d want %0d", g, rr_pick(last, 4'b0010)); else n_pass++;
    last = 1;
    step();
    aref_ask = 1'b1;
    #1;
    n_chk++; if (cif.ch_en !== '0 || busy !== 1'b1 || aref_en !== 1'b0) $display("FAIL pause_drop: got ch_en=%b busy=%b aref_en=%b want 0000/1/0", cif.ch_en, busy, aref_en); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++; if (dq_oe !== 1'b1 || cif.ch_en !== '0 || aref_en !== 1'b0 || gnt_id !== 3'd1)
        $display("FAIL pause_hold: got oe=%b ch_en=%b aref_en=%b gnt=%0d want 1/0000/0/1", dq_oe, cif.ch_en, aref_en, gnt_id);
      else n_pass++;
    end
    cif.ch_end = 4'b0010; cif.ch_ask = '0;
    step();
    cif.ch_end = '0;
    n_chk++; if (busy !== 1'b0 || aref_en !== 1'b0) $display("FAIL pause_exit: got busy=%b aref_en=%b want 0/0", busy, aref_en); else n_pass++;
    step();
    n_chk++; if (aref_en !== 1'b1) $display("FAIL pause_aref: got %b want 1", aref_en); else n_pass++;
    aref_ask = 1'b0; aref_end = 1'b1;
    step();
    aref_end = 1'b0;
    n_chk++; if (aref_en !== 1'b0) $display("FAIL pause_aref_end: got %b want 0", aref_en); else n_pass++;
  endtask

  task automatic test_timeout();
    int g;
    cif.ch_ask = 4'b0001;
    wait_grant(g, 5);
    n_chk++; if (g != 0) $display("FAIL to_grant: got %0d want 0", g); else n_pass++;
    last = 0;
    for (int k = 1; k < TO; k++) begin
      step();
      n_chk++; if (cif.ch_en !== 4'b0001 || err_timeout !== 1'b0) $display("FAIL to_hold%0d: got ch_en=%b err=%b want 0001/0", k, cif.ch_en, err_timeout); else n_pass++;
      if (k == TO - 1) cif.ch_ask = 4'b0011;
    end
    step();
    n_chk++; if (err_timeout !== 1'b1 || cif.ch_en !== '0) $display("FAIL to_fire: got err=%b ch_en=%b want 1/0000", err_timeout, cif.ch_en); else n_pass++;
    step();
    n_chk++; if (err_timeout !== 1'b0) $display("FAIL to_pulse: got err=%b want 0", err_timeout); else n_pass++;
    n_chk++; if (cif.ch_en !== NCH'(1 << rr_pick(last, 4'b0011))) $display("FAIL to_next: got ch_en=%b want client %0d", cif.ch_en, rr_pick(last, 4'b0011)); else n_pass++;
    last = 1;
  endtask

  task automatic test_timeout_edge();
    for (int k = 1; k < TO; k++) begin
      step();
      if (k == 1) cif.ch_ask = '0;
      if (k == 5) cif.ch_end = 4'b1101;
      if (k == 6) begin
        n_chk++; if (cif.ch_en !== 4'b0010) $display("FAIL edge_foreign_end: got ch_en=%b want 0010", cif.ch_en); else n_pass++;
        cif.ch_end = '0;
      end
      if (k == TO - 1) cif.ch_end = 4'b0010;
    end
    step();
    cif.ch_end = '0;
    n_chk++; if (err_timeout !== 1'b0 || busy !== 1'b0) $display("FAIL edge_exit: got err=%b busy=%b want 0/0", err_timeout, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int g;
    cl_wr[2] = 1'b1;
    pack_clients();
    cif.ch_ask = '1;
    wait_grant(g, 5);
    n_chk++; if (g != rr_pick(last, '1)) $display("FAIL mid_grant: got %0d want %0d", g, rr_pick(last, '1)); else n_pass++;
    step();
    n_chk++; if (dq_oe !== 1'b1) $display("FAIL mid_oe: got %b want 1", dq_oe); else n_pass++;
    srst = 1'b1;
    #1;
    n_chk++; if (cif.ch_en !== '0 || busy !== 1'b0) $display("FAIL mid_hold: got ch_en=%b busy=%b want 0", cif.ch_en, busy); else n_pass++;
    step();
    n_chk++; if (sdram_cmd !== 4'b0111 || sdram_addr !== '0 || sdram_bank !== '0 || dq_oe !== 1'b0 || dq_out !== '0 || err_timeout !== 1'b0)
      $display("FAIL mid_outs: got %b/%h/%h oe=%b dq=%h err=%b want 0111/0/0 0/0/0", sdram_cmd, sdram_addr, sdram_bank, dq_oe, dq_out, err_timeout);
    else n_pass++;
    n_chk++; if (gnt_id !== 3'd3 || cif.ch_en !== '0 || aref_en !== 1'b0 || busy !== 1'b0) $display("FAIL mid_ctrl: got gnt=%0d ch_en=%b aref_en=%b busy=%b want 3/0/0/0", gnt_id, cif.ch_en, aref_en, busy); else n_pass++;
    last = NCH - 1;
    srst = 1'b0; aref_ask = 1'b1;
    init_cmd = 4'($urandom); init_addr = AW'($urandom);
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++; if (busy !== 1'b0 || cif.ch_en !== '0 || sdram_cmd !== init_cmd)
        $display("FAIL mid_idle%0d: got busy=%b ch_en=%b cmd=%b want 0/0000/%b", k, busy, cif.ch_en, sdram_cmd, init_cmd);
      else n_pass++;
    end
    aref_ask = 1'b0; init_end = 1'b1;
    step();
    init_end = 1'b0;
    wait_grant(g, 5);
    n_chk++; if (g != 0) $display("FAIL mid_regrant: got %0d want 0", g); else n_pass++;
    cif.ch_end = 4'b0001; cif.ch_ask = '0;
    step();
    cif.ch_end = '0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_round_robin();
    test_aref_priority();
    test_aref_pause();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4: number of access clients (2..8).
REQ-002 SHALL have parameter AW, default 12: SDRAM address width.
REQ-003 SHALL have parameter BW, default 2: bank width.
REQ-004 SHALL have parameter DW, default 16: data width.
REQ-005 SHALL have parameter TIMEOUT, default 255: max cycles a grant or refresh may last before forced release.
REQ-006 SHALL have port sclk  in  1  single clock; all logic rising-edge.
REQ-007 SHALL have port srst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port init_end  in  1  init sequencer done (level or pulse).
REQ-009 SHALL have ports init_cmd  in  4, and init_addr  in  AW, carrying the init sequencer {cs_n,ras_n,cas_n,we_n} and address.
REQ-010 SHALL have ports aref_ask  in  1, and aref_end  in  1, for the refresh request and refresh done.
REQ-011 SHALL have ports aref_cmd  in  4, and aref_addr  in  AW, carrying the refresh command and address.
REQ-012 SHALL have port aref_en  out  1  refresh grant.
REQ-013 SHALL have ports ch_ask  in  NCH, and ch_end  in  NCH, for per-client request and per-client done.
REQ-014 SHALL have ports ch_cmd  in  4*NCH, ch_addr  in  AW*NCH, ch_bank  in  BW*NCH, and ch_wdata  in  DW*NCH, packed with client i at slice i.
REQ-015 SHALL have port ch_wr  in  NCH  client i is a write client (drives DQ).
REQ-016 SHALL have port ch_en  out  NCH  one-hot grant.
REQ-017 SHALL have ports sdram_cmd  out  4, sdram_addr  out  AW, sdram_bank  out  BW, dq_out  out  DW, and dq_oe  out  1, all registered.
REQ-018 SHALL have ports gnt_id  out  3  current/last granted client, busy  out  1  state is AREF or ACCESS, and err_timeout  out  1  one-cycle pulse.

Function
REQ-019 SHALL implement states IDLE, ARBIT, AREF, ACCESS.
REQ-020 SHALL move IDLE->ARBIT on the cycle after init_end=1, and ignore aref_ask and ch_ask while in IDLE.
REQ-021 SHALL, in ARBIT with aref_ask=1, go to AREF, giving refresh strict priority over every client.
REQ-022 SHALL, in ARBIT with aref_ask=0 and any ch_ask bit set, go to ACCESS and latch gnt_id = first set ch_ask bit searching upward from (last gnt_id+1) mod NCH, wrapping (round-robin).
REQ-023 SHALL stay in ARBIT when there is no request.
REQ-024 SHALL move AREF->ARBIT on aref_end=1.
REQ-025 SHALL move ACCESS->ARBIT on ch_end[gnt_id]=1, ignoring ch_end of non-granted clients.
REQ-026 SHALL drive aref_en combinationally as (state==AREF).
REQ-027 SHALL drive ch_en[i] combinationally as (state==ACCESS && gnt_id==i && aref_ask==0): a refresh request pauses the granted client without leaving ACCESS, and the client must finish its burst and assert ch_end.
REQ-028 SHALL drive the output mux source as: IDLE=init_cmd/init_addr with bank 0; AREF=aref_cmd/aref_addr with bank 0; ACCESS=slice gnt_id of ch_cmd/ch_addr/ch_bank; ARBIT=cmd 4'b0111 (NOP) with addr 0 and bank 0.
REQ-029 SHALL register the mux result, so the pins lag the source by exactly 1 cycle.
REQ-030 SHALL register dq_oe = (state==ACCESS && ch_wr[gnt_id]), and register dq_out = ch_wdata slice gnt_id when dq_oe is 1 and 0 otherwise.
REQ-031 SHALL run a watchdog counter that clears on entry to AREF/ACCESS and increments each cycle while in those states.
REQ-032 SHALL, when the watchdog reaches TIMEOUT with no end flag that cycle, force the state to ARBIT and pulse err_timeout for 1 cycle.
REQ-033 SHALL take the normal exit without raising err_timeout when an end flag coincides with the watchdog reaching TIMEOUT.
REQ-034 SHALL keep the round-robin pointer unchanged after a timeout, so the next grant starts at gnt_id+1.
REQ-035 SHALL, when aref_ask and ch_ask arrive together in ARBIT, go to AREF, with the client served on the following ARBIT visit.
REQ-036 SHALL treat a gnt_id>=NCH as unreachable, with the slice select saturating to index 0.

Reset
REQ-037 SHALL on srst=1 at a clock edge, regardless of state (including mid-burst), set state=IDLE, gnt_id=NCH-1 (so first grant searches from 0), watchdog=0, sdram_cmd=4'b0111, sdram_addr=0, sdram_bank=0, dq_out=0, dq_oe=0, err_timeout=0.
REQ-038 SHALL, while srst=1, hold aref_en=0, ch_en=0 and busy=0.

Verification
REQ-039 Bench SHALL cover: reset, init_end pulse at cycle 5 -> ARBIT at cycle 6, sdram_cmd=0111 at cycle 7.
REQ-040 Bench SHALL cover: NCH=4, ch_ask=4'b1111 held, each client asserts ch_end 3 cycles after ch_en -> grants in order 0,1,2,3,0.
REQ-041 Bench SHALL cover: aref_ask and ch_ask[2] both set in ARBIT -> aref_en first; after aref_end, ch_en[2]=1.
REQ-042 Bench SHALL cover: aref_ask rising during ACCESS of write client 1 -> ch_en[1] drops the same cycle, dq_oe stays 1, state stays ACCESS until ch_end[1].
REQ-043 Bench SHALL cover: TIMEOUT=15, client 0 never ends -> exit to ARBIT after 15 ACCESS cycles, err_timeout=1 for one cycle, next grant to client 1 when ch_ask=4'b0011.
REQ-044 Bench SHALL cover: srst asserted mid-ACCESS -> next cycle all outputs at reset values, and init_end is required again.
